// File: rtl/shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier
//   Sequential 8x8 unsigned multiplier. One partial product is added per clock
//   through a single 8-bit ripple adder (no carry-in). The 17-bit value
//   {carry, sum, Q} is shifted right each iteration, so after eight
//   iterations {ACC, Q} holds the full 16-bit product.
//
//   Ports:
//     clk      in   rising-edge clock
//     rst_n    in   asynchronous active-low reset
//     start    in   request, sampled only in IDLE
//     a        in   [7:0] multiplicand, captured on acceptance
//     b        in   [7:0] multiplier, captured on acceptance
//     busy     out  high while in RUN
//     done     out  single-cycle pulse in DONE, product valid
//     product  out  [15:0] registered result, held until next completion
//
//   ripple_adder_8 is the team's 8-bit ripple-carry adder (a + b -> s, cout).
// ---------------------------------------------------------------------------

module ripple_adder_8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] s,
  output logic       cout
);

  logic [8:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign s[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[8];

endmodule

module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  // The arithmetic resource is a fixed 8-bit adder, so no other width works.
  if (WIDTH != 8) begin : g_width_check
    $error("shift_add_multiplier: WIDTH must be 8");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [7:0]   m_q, m_d;
  logic [7:0]   acc_q, acc_d;
  logic [7:0]   q_q, q_d;
  logic [2:0]   count_q, count_d;
  logic [15:0]  product_q, product_d;

  logic [7:0]   add_b;
  logic [7:0]   add_s;
  logic         add_cout;

  // Adder B is explicitly zero when the current multiplier bit is 0.
  assign add_b = q_q[0] ? m_q : 8'h00;

  ripple_adder_8 u_adder (
    .a    (acc_q),
    .b    (add_b),
    .s    (add_s),
    .cout (add_cout)
  );

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    count_d   = count_q;
    product_d = product_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = a;
          q_d     = b;
          acc_d   = 8'h00;
          count_d = 3'd0;
          state_d = RUN;
        end
      end

      RUN: begin
        // Right shift of {cout, sum, Q}: the carry lands in ACC[7] and is
        // never dropped, so 0xFF*0xFF fits.
        acc_d   = {add_cout, add_s[7:1]};
        q_d     = {add_s[0], q_q[7:1]};
        count_d = count_q + 3'd1;
        if (count_q == 3'd7) begin
          product_d = {add_cout, add_s[7:1], add_s[0], q_q[7:1]};
          state_d   = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_q       <= 8'h00;
      acc_q     <= 8'h00;
      q_q       <= 8'h00;
      count_q   <= 3'd0;
      product_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// tb_shift_add_multiplier
//   Directed bench for shift_add_multiplier. Each scenario task drives its own
//   stimulus and compares against hand-computed values. Outputs are sampled
//   on the falling clock edge.
// ---------------------------------------------------------------------------

module tb_shift_add_multiplier;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int checks = 0;
  int errors = 0;

  shift_add_multiplier #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one operation from a falling edge with the DUT idle and observe it
  // for ten cycles; returns at the falling edge where the DUT is idle again.
  // k counts falling edges after the accepting edge: busy expected at k=1..8,
  // done at k=9, idle at k=10.
  task automatic do_mult(input logic [7:0] av, input logic [7:0] bv,
                         input logic [15:0] prev_exp,
                         output logic [15:0] prod, output int busy_cnt,
                         output int done_cnt, output int done_at,
                         output bit held);
    a = av;
    b = bv;
    start = 1'b1;
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = 0;
    held     = 1'b1;
    prod     = 16'h0000;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (busy === 1'b1) begin
        busy_cnt++;
        if (product !== prev_exp) held = 1'b0;
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at == 0) done_at = k;
        prod = product;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    #3;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_outputs: busy=%b done=%b product=%h expected 0 0 0000",
               busy, done, product);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [15:0] p;
    int bc, dc, da;
    bit held;
    do_mult(8'h0D, 8'h0B, 16'h0000, p, bc, dc, da, held);
    checks++;
    if (p !== 16'h008F) begin
      errors++;
      $display("[TB] FAIL basic_product: got %h expected 008f", p);
    end
    checks++;
    if (bc !== 8) begin
      errors++;
      $display("[TB] FAIL basic_busy_cycles: got %0d expected 8", bc);
    end
    checks++;
    if (dc !== 1 || da !== 9) begin
      errors++;
      $display("[TB] FAIL basic_done_pulse: width %0d at %0d expected width 1 at 9", dc, da);
    end
    checks++;
    if (held !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_product_hold: product changed during RUN, expected 0000");
    end
  endtask

  task automatic test_corners();
    logic [7:0]  va [4] = '{8'hFF, 8'h00, 8'hA5, 8'h01};
    logic [7:0]  vb [4] = '{8'hFF, 8'hFF, 8'h00, 8'h80};
    logic [15:0] ve [4] = '{16'hFE01, 16'h0000, 16'h0000, 16'h0080};
    logic [15:0] prev;
    logic [15:0] p;
    int bc, dc, da;
    bit held;
    prev = 16'h008F;
    for (int i = 0; i < 4; i++) begin
      do_mult(va[i], vb[i], prev, p, bc, dc, da, held);
      checks++;
      if (p !== ve[i] || dc !== 1 || da !== 9 || held !== 1'b1) begin
        errors++;
        $display("[TB] FAIL corner_%0d: %h*%h got %h (done w%0d @%0d held %b) expected %h (w1 @9 held 1)",
                 i, va[i], vb[i], p, dc, da, held, ve[i]);
      end
      prev = ve[i];
    end
  endtask

  task automatic test_hold_start();
    int done_at;
    int busy_cnt;
    bit late_accept_ok;
    logic [15:0] p;
    a = 8'h03;
    b = 8'h05;
    start = 1'b1;
    done_at = 0;
    busy_cnt = 0;
    p = 16'h0000;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) a = 8'hFF;
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1 && done_at == 0) begin
        done_at = k;
        p = product;
      end
    end
    checks++;
    if (p !== 16'h000F || done_at !== 9) begin
      errors++;
      $display("[TB] FAIL hold_start_product: got %h at %0d expected 000f at 9", p, done_at);
    end
    checks++;
    if (busy_cnt !== 8 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_start_ignored: busy cycles %0d busy at k10 %b expected 8 and 0",
               busy_cnt, busy);
    end
    // start still high: the next accept happens at the first IDLE edge with a=FF.
    @(negedge clk);
    start = 1'b0;
    late_accept_ok = (busy === 1'b1);
    checks++;
    if (!late_accept_ok) begin
      errors++;
      $display("[TB] FAIL hold_start_reaccept: busy=%b expected 1", busy);
    end
    done_at = 0;
    p = 16'h0000;
    for (int k = 2; k <= 12; k++) begin
      @(negedge clk);
      if (done === 1'b1 && done_at == 0) begin
        done_at = k;
        p = product;
      end
    end
    checks++;
    if (p !== 16'h04FB || done_at !== 9) begin
      errors++;
      $display("[TB] FAIL hold_start_second: got %h at %0d expected 04fb at 9", p, done_at);
    end
  endtask

  task automatic test_reset_abort();
    int spurious;
    logic [15:0] p;
    int bc, dc, da;
    bit held;
    a = 8'h12;
    b = 8'h34;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_pre_busy: busy=%b expected 1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL abort_immediate: busy=%b done=%b product=%h expected 0 0 0000",
               busy, done, product);
    end
    spurious = 0;
    repeat (2) begin
      @(negedge clk);
      if (done !== 1'b0) spurious++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) spurious++;
    end
    checks++;
    if (spurious !== 0) begin
      errors++;
      $display("[TB] FAIL abort_no_done: %0d active cycles expected 0", spurious);
    end
    do_mult(8'h12, 8'h34, 16'h0000, p, bc, dc, da, held);
    checks++;
    if (p !== 16'h03A8 || dc !== 1 || da !== 9) begin
      errors++;
      $display("[TB] FAIL abort_rerun: got %h (w%0d @%0d) expected 03a8 (w1 @9)", p, dc, da);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  av, bv;
    logic [15:0] exp_p, prev;
    logic [15:0] p;
    int bc, dc, da;
    bit held;
    prev = 16'h03A8;
    for (int i = 0; i < 300; i++) begin
      av = 8'($urandom_range(0, 255));
      bv = 8'($urandom_range(0, 255));
      exp_p = 16'(av) * 16'(bv);
      do_mult(av, bv, prev, p, bc, dc, da, held);
      checks++;
      if (p !== exp_p || dc !== 1 || da !== 9 || bc !== 8 || held !== 1'b1) begin
        errors++;
        $display("[TB] FAIL sweep_%0d: %h*%h got %h (w%0d @%0d busy %0d held %b) expected %h",
                 i, av, bv, p, dc, da, bc, held, exp_p);
      end
      prev = exp_p;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_hold_start();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
